// File: rtl/construtor_caminho.sv
// Path-construction engine: walks the predecessor memory from destino back to
// fonte, stacking each node, then streams the path fonte-first over valid/ready.
module construtor_caminho #(
  parameter int ADDR_WIDTH  = 10,
  parameter int MAX_CAMINHO = 64,
  parameter int RD_LATENCY  = 1,
  parameter int LEN_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  construir_in,
  input  logic [ADDR_WIDTH-1:0] fonte_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_out,
  input  logic [ADDR_WIDTH-1:0] mem_rd_data_in,
  output logic                  caminho_valid_out,
  output logic [ADDR_WIDTH-1:0] caminho_data_out,
  output logic                  caminho_ultimo_out,
  input  logic                  caminho_ready_in,
  output logic                  caminho_pronto_out,
  output logic                  erro_out,
  output logic                  ocupado_out,
  output logic [LEN_WIDTH-1:0]  comprimento_out,
  output logic [1:0]            estado_out
);

  // Handshake: a path word transfers on any rising clk edge where
  // caminho_valid_out && caminho_ready_in; while ready is low the word,
  // ultimo and valid stay unchanged, and valid never drops before transfer.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LER    = 2'd1,
    ESPERA = 2'd2,
    ENVIA  = 2'd3
  } estado_t;

  localparam int CNT_WIDTH = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int IDX_WIDTH = $clog2(MAX_CAMINHO);
  localparam logic [CNT_WIDTH-1:0] CNT_INICIAL = CNT_WIDTH'(RD_LATENCY - 1);
  localparam logic [LEN_WIDTH-1:0] SP_MAX      = LEN_WIDTH'(MAX_CAMINHO);
  localparam logic [LEN_WIDTH-1:0] SP_UM       = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] SP_DOIS     = LEN_WIDTH'(2);

  estado_t               r_estado;
  logic [LEN_WIDTH-1:0]  r_sp;
  logic [LEN_WIDTH-1:0]  r_comp;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [ADDR_WIDTH-1:0] r_fonte;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_rd_en;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_dado;
  logic                  r_ultimo;
  logic                  r_pronto;
  logic                  r_erro;

  // Stack storage carries no reset: entries above sp are never read.
  logic [ADDR_WIDTH-1:0] r_pilha [MAX_CAMINHO];

  logic                  w_amostra;
  logic                  w_push;
  logic [IDX_WIDTH-1:0]  w_push_idx;
  logic [ADDR_WIDTH-1:0] w_push_dado;
  logic [IDX_WIDTH-1:0]  w_prox_idx;
  logic [ADDR_WIDTH-1:0] w_prox_dado;

  always_comb begin
    w_amostra   = (r_estado == ESPERA) && (r_cnt == '0);
    w_push      = ((r_estado == IDLE) && construir_in) ||
                  (w_amostra && (r_sp != SP_MAX));
    w_push_idx  = (r_estado == IDLE) ? '0 : IDX_WIDTH'(r_sp);
    w_push_dado = (r_estado == IDLE) ? destino_in : mem_rd_data_in;
    // Word below the one currently presented; only used while sp >= 2.
    w_prox_idx  = IDX_WIDTH'(r_sp - SP_DOIS);
    w_prox_dado = r_pilha[w_prox_idx];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pilha[w_push_idx] <= w_push_dado;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
      r_sp     <= '0;
      r_comp   <= '0;
      r_cur    <= '0;
      r_fonte  <= '0;
      r_cnt    <= '0;
      r_rd_en  <= 1'b0;
      r_valid  <= 1'b0;
      r_dado   <= '0;
      r_ultimo <= 1'b0;
      r_pronto <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_rd_en  <= 1'b0;
      r_pronto <= 1'b0;
      r_erro   <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (construir_in) begin
            r_fonte <= fonte_in;
            r_cur   <= destino_in;
            r_sp    <= SP_UM;
            r_comp  <= SP_UM;
            if (destino_in == fonte_in) begin
              r_estado <= ENVIA;
              r_valid  <= 1'b1;
              r_dado   <= destino_in;
              r_ultimo <= 1'b1;
            end else begin
              r_estado <= LER;
              r_rd_en  <= 1'b1;
            end
          end
        end
        LER: begin
          r_cnt    <= CNT_INICIAL;
          r_estado <= ESPERA;
        end
        ESPERA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
          end else if (r_sp == SP_MAX) begin
            // Another node would not fit: loop or unreachable fonte.
            r_erro   <= 1'b1;
            r_sp     <= '0;
            r_estado <= IDLE;
          end else begin
            r_sp   <= r_sp + SP_UM;
            r_comp <= r_comp + SP_UM;
            r_cur  <= mem_rd_data_in;
            if (mem_rd_data_in == r_fonte) begin
              r_estado <= ENVIA;
              r_valid  <= 1'b1;
              r_dado   <= mem_rd_data_in;
              r_ultimo <= 1'b0;
            end else begin
              r_estado <= LER;
              r_rd_en  <= 1'b1;
            end
          end
        end
        ENVIA: begin
          if (caminho_ready_in) begin
            if (r_sp == SP_UM) begin
              r_valid  <= 1'b0;
              r_dado   <= '0;
              r_ultimo <= 1'b0;
              r_pronto <= 1'b1;
              r_sp     <= '0;
              r_estado <= IDLE;
            end else begin
              r_sp     <= r_sp - SP_UM;
              r_dado   <= w_prox_dado;
              r_ultimo <= (r_sp == SP_DOIS);
            end
          end
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  assign mem_rd_en_out      = r_rd_en;
  assign mem_rd_addr_out    = r_rd_en ? r_cur : '0;
  assign caminho_valid_out  = r_valid;
  assign caminho_data_out   = r_dado;
  assign caminho_ultimo_out = r_ultimo;
  assign caminho_pronto_out = r_pronto;
  assign erro_out           = r_erro;
  assign ocupado_out        = (r_estado != IDLE);
  assign comprimento_out    = r_comp;
  assign estado_out         = r_estado;

  a_sp_limite : assert property (@(posedge clk) disable iff (!rst_n)
    r_sp <= SP_MAX);
  a_leitura_em_ler : assert property (@(posedge clk) disable iff (!rst_n)
    r_rd_en |-> (r_estado == LER));
  a_envia_nao_vazio : assert property (@(posedge clk) disable iff (!rst_n)
    (r_estado == ENVIA) |-> (r_sp != '0) && r_valid);

endmodule
